debug_dump_sequencer: RTL and testbench

Command-driven controller that sequences the pipeline debug path: decodes single-byte commands from the UART receiver, issues one-cycle pipeline step enables, then walks a word-select index over the externally muxed debug words (PC, instruction, register file) and pushes each word into the TX byte FIFO, least-significant byte first. It sits between `uart_rx`, the pipeline's step enable, the debug-word mux and the `fifo` feeding `uart_tx`. FIFO backpressure is honoured, so no byte is ever written while the FIFO is full.

---
 rtl/debug_dump_sequencer.sv | 146 ++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: decodes UART commands, pulses the pipeline step enable and streams the
// debug words into the TX FIFO LSB first. Define DEBUG_DUMP_HEADER_EN to prefix each frame with A5, NUM_WORDS.
module debug_dump_sequencer #(
  parameter int          NUM_WORDS     = 34,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  STEP_CMD      = 8'h41,
  parameter logic [7:0]  DUMP_CMD      = 8'h44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  input  logic        fifo_full,
  input  logic [31:0] word_in,
  output logic [5:0]  word_sel,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  output logic        pipe_step,
  output logic        busy,
  output logic        dump_done
);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
`ifdef DEBUG_DUMP_HEADER_EN
    HDR,
`endif
    DUMP,
    DONE
  } state_t;

`ifdef DEBUG_DUMP_HEADER_EN
  localparam state_t     FIRST_XFER = HDR;
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] COUNT_BYTE = 8'(NUM_WORDS);
`else
  localparam state_t     FIRST_XFER = DUMP;
`endif
  localparam state_t     AFTER_STEP  = (SETTLE_CYCLES == 0) ? FIRST_XFER : SETTLE;
  localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [5:0] LAST_WORD   = 6'(NUM_WORDS - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [1:0] byte_idx;
`ifdef DEBUG_DUMP_HEADER_EN
  logic       hdr_idx;
`endif

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = word[7:0];
      2'd1:    byte_of = word[15:8];
      2'd2:    byte_of = word[23:16];
      default: byte_of = word[31:24];
    endcase
  endfunction

  // Write strobe follows the full flag directly so a byte is never pushed into a full FIFO.
  always_comb begin
    fifo_wr_en = 1'b0;
    fifo_din   = 8'h00;
    case (state)
`ifdef DEBUG_DUMP_HEADER_EN
      HDR: begin
        fifo_wr_en = !fifo_full;
        fifo_din   = hdr_idx ? COUNT_BYTE : SYNC_BYTE;
      end
`endif
      DUMP: begin
        fifo_wr_en = !fifo_full;
        fifo_din   = byte_of(word_in, byte_idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_sel   <= 6'd0;
      byte_idx   <= 2'd0;
      settle_cnt <= 4'd0;
      pipe_step  <= 1'b0;
      busy       <= 1'b0;
      dump_done  <= 1'b0;
`ifdef DEBUG_DUMP_HEADER_EN
      hdr_idx    <= 1'b0;
`endif
    end else begin
      pipe_step <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_data_rdy && rx_data == STEP_CMD) begin
            state     <= STEP;
            pipe_step <= 1'b1;
            busy      <= 1'b1;
          end else if (rx_data_rdy && rx_data == DUMP_CMD) begin
            state <= FIRST_XFER;
            busy  <= 1'b1;
          end
        end
        STEP: begin
          state      <= AFTER_STEP;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) state <= FIRST_XFER;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end
`ifdef DEBUG_DUMP_HEADER_EN
        HDR: begin
          if (!fifo_full) begin
            hdr_idx <= ~hdr_idx;
            if (hdr_idx) state <= DUMP;
          end
        end
`endif
        // Index advances only on an accepted byte, so backpressure simply freezes w and b.
        DUMP: begin
          if (!fifo_full) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (word_sel == LAST_WORD) begin
                state     <= DONE;
                dump_done <= 1'b1;
                word_sel  <= 6'd0;
              end else begin
                word_sel <= word_sel + 6'd1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer: default instance plus a NUM_WORDS=1, SETTLE_CYCLES=0 instance.
module tb_debug_dump_sequencer;

`ifdef DEBUG_DUMP_HEADER_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy0, rx_rdy1;
  logic        fifo_full, fifo_full1;
  logic [31:0] word_in, word_in1;
  logic [5:0]  word_sel, word_sel1;
  logic [7:0]  fifo_din, fifo_din1;
  logic        fifo_wr_en, fifo_wr_en1;
  logic        pipe_step, pipe_step1;
  logic        busy, busy1;
  logic        dump_done, dump_done1;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp_q1[$];
  int checks = 0, errors = 0;
  int writes = 0, steps = 0, dones = 0;
  int writes1 = 0, steps1 = 0, dones1 = 0;
  int s0, w0, d0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [5:0] w);
    int b;
    b = 4 * int'(w);
    return {8'(b + 4), 8'(b + 3), 8'(b + 2), 8'(b + 1)};
  endfunction

  assign word_in  = word_of(word_sel);
  assign word_in1 = 32'hDDCC_BBAA;

  debug_dump_sequencer dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_rdy0),
    .fifo_full(fifo_full), .word_in(word_in), .word_sel(word_sel),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .pipe_step(pipe_step),
    .busy(busy), .dump_done(dump_done)
  );

  debug_dump_sequencer #(.NUM_WORDS(1), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_rdy1),
    .fifo_full(fifo_full1), .word_in(word_in1), .word_sel(word_sel1),
    .fifo_din(fifo_din1), .fifo_wr_en(fifo_wr_en1), .pipe_step(pipe_step1),
    .busy(busy1), .dump_done(dump_done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected byte whenever a write strobe is presented.
  always @(negedge clk) begin
    if (pipe_step === 1'b1) steps++;
    if (dump_done === 1'b1) dones++;
    if (fifo_wr_en === 1'b1) begin
      check("wr_en_while_full", 32'(fifo_full), 32'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got %0h, expected no write", fifo_din);
      end else begin
        check($sformatf("byte%0d", writes), 32'(fifo_din), 32'(exp_q.pop_front()));
      end
      writes++;
    end
  end

  always @(negedge clk) begin
    if (pipe_step1 === 1'b1) steps1++;
    if (dump_done1 === 1'b1) dones1++;
    if (fifo_wr_en1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write1: got %0h, expected no write", fifo_din1);
      end else begin
        check($sformatf("dut1_byte%0d", writes1), 32'(fifo_din1), 32'(exp_q1.pop_front()));
      end
      writes1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] b);
    rx_data = b; rx_rdy0 = 1'b1;
    tick();
    rx_rdy0 = 1'b0;
  endtask

  task automatic push_dump(input int n);
`ifdef DEBUG_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'd34);
`endif
    for (int k = 0; k < n; k++) exp_q.push_back(8'(k + 1));
  endtask

  task automatic wait_done0(input int budget);
    int n;
    n = 0;
    while (dump_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (dump_done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no dump_done, expected within %0d cycles", budget);
    end
  endtask

  task automatic snap();
    s0 = steps; w0 = writes; d0 = dones;
  endtask

  task automatic check_totals(input string tag, input int nsteps);
    check({tag, "_writes"}, 32'(writes - w0), 32'(136 + HDR_N));
    check({tag, "_steps"}, 32'(steps - s0), 32'(nsteps));
    check({tag, "_dones"}, 32'(dones - d0), 32'd1);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_rdy0 = 1'b0; rx_rdy1 = 1'b0;
    fifo_full = 1'b0; fifo_full1 = 1'b0;
    repeat (3) tick();
    check("rst_word_sel", 32'(word_sel), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_pipe_step", 32'(pipe_step), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dump_done", 32'(dump_done), 32'd0);
    rst = 1'b0;
    tick();

    // Step and dump, with a second 'A' during the dump that must be dropped.
    push_dump(136); snap();
    send0(8'h41);
    check("step_pulse", 32'(pipe_step), 32'd1);
    check("step_busy", 32'(busy), 32'd1);
    check("step_no_wr", 32'(fifo_wr_en), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("settle_no_step", 32'(pipe_step), 32'd0);
      check("settle_no_wr", 32'(fifo_wr_en), 32'd0);
    end
    tick();
    check("first_wr", 32'(fifo_wr_en), 32'd1);
    check("first_word_sel", 32'(word_sel), 32'd0);
    send0(8'h41);
    wait_done0(400);
    tick();
    check("a_busy_low", 32'(busy), 32'd0);
    check_totals("a", 1);

    // Unknown byte in IDLE.
    send0(8'h58);
    check("x_busy", 32'(busy), 32'd0);
    check("x_step", 32'(pipe_step), 32'd0);
    tick();
    check("x_wr", 32'(fifo_wr_en), 32'd0);

    // 'D' dump with 5 cycles of backpressure at w=3, b=2; a 'D' in the DONE cycle is dropped.
    push_dump(136); snap();
    send0(8'h44);
    check("d_first_wr", 32'(fifo_wr_en), 32'd1);
    repeat (14 + HDR_N) tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_no_wr", 32'(fifo_wr_en), 32'd0);
      check("bp_word_sel", 32'(word_sel), 32'd3);
      tick();
    end
    fifo_full = 1'b0;
    wait_done0(400);
    rx_data = 8'h44; rx_rdy0 = 1'b1;
    tick();
    rx_rdy0 = 1'b0;
    check("d_busy_low", 32'(busy), 32'd0);
    tick();
    check("done_cmd_dropped", 32'(busy), 32'd0);
    check("done_cmd_no_wr", 32'(fifo_wr_en), 32'd0);
    check_totals("d", 0);

    // Reset while byte 50 is written, with a coincident command that must be ignored.
    push_dump(51);
    send0(8'h44);
    repeat (50 + HDR_N) tick();
    rst = 1'b1; rx_data = 8'h41; rx_rdy0 = 1'b1;
    tick();
    rst = 1'b0; rx_rdy0 = 1'b0;
    check("mid_rst_word_sel", 32'(word_sel), 32'd0);
    check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("mid_rst_din", 32'(fifo_din), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_step", 32'(pipe_step), 32'd0);
    check("mid_rst_done", 32'(dump_done), 32'd0);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    push_dump(136); snap();
    send0(8'h44);
    check("restart_word_sel", 32'(word_sel), 32'd0);
    wait_done0(400);
    tick();
    check_totals("r", 0);

    // Single-word instance with no settle time.
`ifdef DEBUG_DUMP_HEADER_EN
    exp_q1.push_back(8'hA5);
    exp_q1.push_back(8'h01);
`endif
    exp_q1.push_back(8'hAA); exp_q1.push_back(8'hBB);
    exp_q1.push_back(8'hCC); exp_q1.push_back(8'hDD);
    rx_data = 8'h41; rx_rdy1 = 1'b1;
    tick();
    rx_rdy1 = 1'b0;
    check("s0_step", 32'(pipe_step1), 32'd1);
    check("s0_no_wr", 32'(fifo_wr_en1), 32'd0);
    tick();
    check("s0_wr_immediate", 32'(fifo_wr_en1), 32'd1);
    repeat (4 + HDR_N) tick();
    check("s0_done", 32'(dump_done1), 32'd1);
    check("s0_done_no_wr", 32'(fifo_wr_en1), 32'd0);
    check("s0_word_sel", 32'(word_sel1), 32'd0);
    tick();
    check("s0_busy_low", 32'(busy1), 32'd0);
    check("s0_writes", 32'(writes1), 32'(4 + HDR_N));
    check("s0_steps", 32'(steps1), 32'd1);
    check("s0_dones", 32'(dones1), 32'd1);
    check("s0_queue_left", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
